// File: rtl/lap_split_if.sv
// Bus between the stopwatch/button side and the lap/split capture stage.
// master drives the live time and button levels; slave drives the display side.
interface lap_split_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic [WIDTH-1:0] time_in;
    logic             running;
    logic             lap_btn;
    logic             recall_btn;
    logic             clear_btn;
    logic [WIDTH-1:0] display_number;
    logic [CW-1:0]    lap_count;
    logic [CW-1:0]    recall_idx;
    logic             overflow;
    logic [1:0]       state_out;

    modport master (
        output time_in, running, lap_btn, recall_btn, clear_btn,
        input  display_number, lap_count, recall_idx, overflow, state_out
    );

    modport slave (
        input  time_in, running, lap_btn, recall_btn, clear_btn,
        output display_number, lap_count, recall_idx, overflow, state_out
    );
endinterface

// File: rtl/lap_split_buffer.sv
// Lap/split capture stage: passes live time to the display, freezes it on a lap
// press while storing the time, and lets stored laps be recalled one by one.
module lap_split_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    lap_split_if.slave  bus
);
    // Address width of the lap memory; a single-entry buffer still gets one bit.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] LIVE   = 2'd0;
    localparam logic [1:0] SPLIT  = 2'd1;
    localparam logic [1:0] RECALL = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] display_q;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    lap_count;
    logic [CW-1:0]    recall_idx;
    logic             overflow;
    logic             lap_q, recall_q, clear_q;

    logic [WIDTH-1:0] lap_mem [0:(1 << AW)-1];

    logic             lap_e, recall_e, clear_e;
    logic             wr_en;
    logic [CW-1:0]    rd_idx;

    // Rising-edge detect against the previous button level.
    assign lap_e    = bus.lap_btn    & ~lap_q;
    assign recall_e = bus.recall_btn & ~recall_q;
    assign clear_e  = bus.clear_btn  & ~clear_q;

    // recall_idx is 1-based and only nonzero in RECALL, so the subtract never underflows there.
    assign rd_idx = recall_idx - 1'b1;

    // A lap is stored only from LIVE, while running, with room left, and no clear pending.
    always_comb begin
        wr_en = 1'b0;
        if (!rst && !clear_e && state == LIVE && lap_e && bus.running && lap_count < DEPTH_C)
            wr_en = 1'b1;
    end

    // Lap memory is not reset; entries at or above lap_count are never read.
    always_ff @(posedge clk) begin
        if (wr_en)
            lap_mem[lap_count[AW-1:0]] <= bus.time_in;
    end

    // Button history; reset high so a button held through reset produces no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q    <= 1'b1;
            recall_q <= 1'b1;
            clear_q  <= 1'b1;
        end else begin
            lap_q    <= bus.lap_btn;
            recall_q <= bus.recall_btn;
            clear_q  <= bus.clear_btn;
        end
    end

    // Display source follows the current state, so it lags a state change by one cycle.
    always_ff @(posedge clk) begin
        if (rst)
            display_q <= '0;
        else begin
            case (state)
                SPLIT:   display_q <= hold;
                RECALL:  display_q <= lap_mem[rd_idx[AW-1:0]];
                default: display_q <= bus.time_in;
            endcase
        end
    end

    // State/counter update; clear beats lap beats recall, one event per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LIVE;
            hold       <= '0;
            lap_count  <= '0;
            recall_idx <= '0;
            overflow   <= 1'b0;
        end else if (clear_e) begin
            state      <= LIVE;
            lap_count  <= '0;
            recall_idx <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                LIVE: begin
                    if (lap_e) begin
                        // A lap while stopped is ignored and also swallows any recall.
                        if (bus.running) begin
                            hold  <= bus.time_in;
                            state <= SPLIT;
                            if (lap_count < DEPTH_C)
                                lap_count <= lap_count + 1'b1;
                            else
                                overflow <= 1'b1;
                        end
                    end else if (recall_e && lap_count != '0) begin
                        recall_idx <= CW'(1);
                        state      <= RECALL;
                    end
                end
                SPLIT: begin
                    if (lap_e)
                        state <= LIVE;
                end
                RECALL: begin
                    if (lap_e) begin
                        recall_idx <= '0;
                        state      <= LIVE;
                    end else if (recall_e) begin
                        if (recall_idx < lap_count)
                            recall_idx <= recall_idx + 1'b1;
                        else begin
                            recall_idx <= '0;
                            state      <= LIVE;
                        end
                    end
                end
                default: begin
                    recall_idx <= '0;
                    state      <= LIVE;
                end
            endcase
        end
    end

    assign bus.display_number = display_q;
    assign bus.lap_count      = lap_count;
    assign bus.recall_idx     = recall_idx;
    assign bus.overflow       = overflow;
    assign bus.state_out      = state;
endmodule
